// File: rtl/md_audio_pkg.sv
// Shared widths, constants and the output saturation helper for the
// Mega Drive audio mixer.
package md_audio_pkg;

  localparam int         CH_COUNT = 6;
  localparam logic [2:0] IDX_IDLE = 3'd7;
  localparam int         FM_W     = 9;
  localparam int         ACC_W    = 12;
  localparam int         MIX_W    = 18;
  localparam int         SAMPLE_W = 16;

  // Clamp an 18-bit mix value into the 16-bit PCM range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [MIX_W-1:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7fff;
    end else if (v < 18'sh38000) begin
      return 16'sh8000;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/md_audio_frame_acc.sv
// Rebuilds one stereo FM frame from the time-multiplexed YM3438 slot outputs:
// fm_clk1 edge detect, slot tracking, per-channel accumulation and frame close.
module md_audio_frame_acc
  import md_audio_pkg::*;
#(
  parameter int CH_SLOTS = CH_COUNT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fm_clk1,
  input  logic [2:0]              ch_idx,
  input  logic signed [FM_W-1:0]  mol,
  input  logic signed [FM_W-1:0]  mor,
  input  logic [15:0]             psg,
  input  logic [5:0]              ch_mask,
  output logic signed [ACC_W-1:0] frame_l_p0,
  output logic signed [ACC_W-1:0] frame_r_p0,
  output logic [15:0]             psg_p0,
  output logic                    vld_p0,
  output logic                    frame_err
);

  logic                    clk_q;
  logic [2:0]              last_idx;
  logic [2:0]              slot_cnt;
  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;

  logic                    fm_edge;
  logic                    slot_new;
  logic                    frame_close;
  logic                    idle_edge;
  logic [7:0]              mask_ext;
  logic signed [ACC_W-1:0] add_l;
  logic signed [ACC_W-1:0] add_r;

  always_comb begin
    fm_edge     = fm_clk1 & ~clk_q;
    slot_new    = fm_edge && (ch_idx < 3'd6) && (ch_idx != last_idx);
    // Slot 0 only closes a frame once at least one slot has been gathered.
    frame_close = slot_new && (ch_idx == 3'd0) && (slot_cnt != 3'd0);
    idle_edge   = fm_edge && (ch_idx >= 3'd6);
    mask_ext    = {2'b00, ch_mask};
    add_l       = mask_ext[ch_idx] ? ACC_W'(mol) : '0;
    add_r       = mask_ext[ch_idx] ? ACC_W'(mor) : '0;
  end

  // Stage p0: slot capture and frame close
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q      <= 1'b0;
      last_idx   <= IDX_IDLE;
      slot_cnt   <= 3'd0;
      acc_l      <= '0;
      acc_r      <= '0;
      frame_l_p0 <= '0;
      frame_r_p0 <= '0;
      psg_p0     <= '0;
      vld_p0     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_q  <= fm_clk1;
      vld_p0 <= frame_close;
      if (frame_close) begin
        frame_l_p0 <= acc_l;
        frame_r_p0 <= acc_r;
        psg_p0     <= psg;
        acc_l      <= add_l;
        acc_r      <= add_r;
        slot_cnt   <= 3'd1;
        last_idx   <= ch_idx;
        if (slot_cnt != 3'(CH_SLOTS)) begin
          frame_err <= 1'b1;
        end
      end else if (slot_new) begin
        acc_l    <= acc_l + add_l;
        acc_r    <= acc_r + add_r;
        last_idx <= ch_idx;
        if (slot_cnt != 3'd7) begin
          slot_cnt <= slot_cnt + 3'd1;
        end
      end else if (idle_edge) begin
        last_idx <= IDX_IDLE;
      end
    end
  end

endmodule

// File: rtl/md_audio_mixer.sv
// Mixes the rebuilt FM frame with the PSG level and emits saturated 16-bit
// stereo PCM with a one-cycle valid strobe.
module md_audio_mixer #(
  parameter int FM_SHIFT  = 4,
  parameter int PSG_SHIFT = 2,
  parameter int CH_COUNT  = md_audio_pkg::CH_COUNT
) (
  input  logic               MCLK,
  input  logic               SRES,
  input  logic               fm_clk1,
  input  logic [2:0]         DAC_ch_index,
  input  logic signed [8:0]  MOL,
  input  logic signed [8:0]  MOR,
  input  logic [15:0]        PSG,
  input  logic [5:0]         ch_mask,
  input  logic               mute,
  output logic signed [15:0] sample_l,
  output logic signed [15:0] sample_r,
  output logic               sample_valid,
  output logic               frame_err
);

  import md_audio_pkg::*;

  logic signed [ACC_W-1:0] frame_l_p0;
  logic signed [ACC_W-1:0] frame_r_p0;
  logic [15:0]             psg_p0;
  logic                    vld_p0;

  logic signed [MIX_W-1:0] fm_l;
  logic signed [MIX_W-1:0] fm_r;
  logic signed [MIX_W-1:0] ps;
  logic signed [MIX_W-1:0] mix_l_p1;
  logic signed [MIX_W-1:0] mix_r_p1;
  logic                    vld_p1;

  md_audio_frame_acc #(
    .CH_SLOTS (CH_COUNT)
  ) u_frame_acc (
    .clk        (MCLK),
    .rst_n      (SRES),
    .fm_clk1    (fm_clk1),
    .ch_idx     (DAC_ch_index),
    .mol        (MOL),
    .mor        (MOR),
    .psg        (PSG),
    .ch_mask    (ch_mask),
    .frame_l_p0 (frame_l_p0),
    .frame_r_p0 (frame_r_p0),
    .psg_p0     (psg_p0),
    .vld_p0     (vld_p0),
    .frame_err  (frame_err)
  );

  always_comb begin
    fm_l = MIX_W'(frame_l_p0) <<< FM_SHIFT;
    fm_r = MIX_W'(frame_r_p0) <<< FM_SHIFT;
    ps   = $signed({2'b00, psg_p0} >> PSG_SHIFT);
  end

  // Stage p1: FM scale plus PSG mix
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      mix_l_p1 <= '0;
      mix_r_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        mix_l_p1 <= fm_l + ps;
        mix_r_p1 <= fm_r + ps;
      end
    end
  end

  // Stage p2: saturation, mute and output strobe
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vld_p1;
      if (vld_p1) begin
        sample_l <= mute ? '0 : sat_sample(mix_l_p1);
        sample_r <= mute ? '0 : sat_sample(mix_r_p1);
      end
    end
  end

endmodule

// File: tb/tb_md_audio_mixer.sv
// Self-checking bench for md_audio_mixer: directed scenarios plus randomized
// slot streams compared against a frame-level behavioural model.
module tb_md_audio_mixer;

  logic               MCLK = 1'b0;
  logic               SRES = 1'b1;
  logic               fm_clk1 = 1'b0;
  logic [2:0]         DAC_ch_index = 3'd7;
  logic [8:0]         MOL = '0;
  logic [8:0]         MOR = '0;
  logic [15:0]        PSG = '0;
  logic [5:0]         ch_mask = 6'h3f;
  logic               mute = 1'b0;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic               sample_valid;
  logic               frame_err;

  md_audio_mixer dut (
    .MCLK         (MCLK),
    .SRES         (SRES),
    .fm_clk1      (fm_clk1),
    .DAC_ch_index (DAC_ch_index),
    .MOL          (MOL),
    .MOR          (MOR),
    .PSG          (PSG),
    .ch_mask      (ch_mask),
    .mute         (mute),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 MCLK = ~MCLK;

  int unsigned cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
    logic [31:0]        cyc;
  } smp_t;

  smp_t exp_q[$];
  smp_t obs_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Model state: the slot contributions gathered in the open frame.
  int m_last = 7;
  int m_l[$];
  int m_r[$];
  bit m_err = 1'b0;

  always @(negedge MCLK) begin
    if (sample_valid === 1'b1) obs_q.push_back('{sample_l, sample_r, cyc});
  end

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic mdl_edge(input logic [2:0] idx, input logic [8:0] mol, input logic [8:0] mor);
    int   sl;
    int   sr;
    smp_t e;
    if (idx > 3'd5) begin
      m_last = 7;
      return;
    end
    if (int'(idx) == m_last) return;
    if (idx == 3'd0 && m_l.size() > 0) begin
      sl = 0;
      sr = 0;
      foreach (m_l[i]) begin
        sl += m_l[i];
        sr += m_r[i];
      end
      if (m_l.size() != 6) m_err = 1'b1;
      e.l   = mute ? 16'sd0 : 16'(clamp16(sl * 16 + int'(PSG) / 4));
      e.r   = mute ? 16'sd0 : 16'(clamp16(sr * 16 + int'(PSG) / 4));
      e.cyc = cyc + 3;
      exp_q.push_back(e);
      m_l.delete();
      m_r.delete();
    end
    if (((ch_mask >> idx) & 6'd1) != 6'd0) begin
      m_l.push_back(int'($signed(mol)));
      m_r.push_back(int'($signed(mor)));
    end else begin
      m_l.push_back(0);
      m_r.push_back(0);
    end
    m_last = int'(idx);
  endtask

  // One fm_clk1 period: high for one MCLK, low for the rest.
  task automatic send(input logic [2:0] idx, input logic [8:0] mol, input logic [8:0] mor, input int period);
    DAC_ch_index = idx;
    MOL          = mol;
    MOR          = mor;
    fm_clk1      = 1'b1;
    mdl_edge(idx, mol, mor);
    @(negedge MCLK);
    fm_clk1 = 1'b0;
    repeat (period - 1) @(negedge MCLK);
  endtask

  task automatic mdl_clear();
    m_last = 7;
    m_l.delete();
    m_r.delete();
    m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    fm_clk1 = 1'b0;
    SRES    = 1'b0;
    mdl_clear();
    obs_q.delete();
    repeat (2) @(negedge MCLK);
    SRES = 1'b1;
    @(negedge MCLK);
  endtask

  task automatic test_reset();
    #2 SRES = 1'b0;
    #1;
    n_assert++;
    if (sample_l !== 16'sd0) begin n_fail++; $display("FAIL reset_sample_l: got %0d, want 0", sample_l); end
    n_assert++;
    if (sample_r !== 16'sd0) begin n_fail++; $display("FAIL reset_sample_r: got %0d, want 0", sample_r); end
    n_assert++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, want 0", sample_valid); end
    n_assert++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, want 0", frame_err); end
    repeat (2) @(negedge MCLK);
    SRES = 1'b1;
    mdl_clear();
    obs_q.delete();
    repeat (4) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL reset_idle_valid: got %0d pulses, want 0", obs_q.size()); end
  endtask

  task automatic test_basic();
    do_reset();
    ch_mask = 6'h3f;
    PSG     = 16'h0000;
    for (int s = 0; s < 6; s++) send(3'(s), 9'd10, 9'h1f6, 3);
    send(3'd0, 9'd255, 9'h100, 3);
    repeat (2) @(negedge MCLK);
    n_assert++;
    if (sample_l !== 16'sd960) begin n_fail++; $display("FAIL basic_l: got %0d, want 960", sample_l); end
    n_assert++;
    if (sample_r !== -16'sd960) begin n_fail++; $display("FAIL basic_r: got %0d, want -960", sample_r); end
    for (int s = 1; s < 6; s++) send(3'(s), 9'd255, 9'h100, 2);
    PSG = 16'hffff;
    send(3'd0, 9'd0, 9'd0, 2);
    repeat (2) @(negedge MCLK);
    n_assert++;
    if (sample_l !== 16'sd32767) begin n_fail++; $display("FAIL sat_l: got %0d, want 32767", sample_l); end
    n_assert++;
    if (sample_r !== -16'sd8193) begin n_fail++; $display("FAIL sat_r: got %0d, want -8193", sample_r); end
    repeat (6) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_sample%0d: got l=%0d r=%0d cyc=%0d, want l=%0d r=%0d cyc=%0d", i, obs_q[i].l, obs_q[i].r, obs_q[i].cyc, exp_q[i].l, exp_q[i].r, exp_q[i].cyc); end
    end
    n_assert++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err: got %b, want 0", frame_err); end
  endtask

  task automatic test_hold();
    do_reset();
    ch_mask = 6'h3f;
    PSG     = 16'h0000;
    send(3'd0, 9'd0, 9'd0, 2);
    send(3'd1, 9'd0, 9'd0, 2);
    repeat (5) send(3'd2, 9'd1, 9'd1, 2);
    for (int s = 3; s < 6; s++) send(3'(s), 9'd0, 9'd0, 3);
    send(3'd0, 9'd0, 9'd0, 2);
    repeat (6) @(negedge MCLK);
    n_assert++;
    if (sample_l !== 16'sd16) begin n_fail++; $display("FAIL hold_l: got %0d, want 16", sample_l); end
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL hold_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hold_sample%0d: got l=%0d r=%0d cyc=%0d, want l=%0d r=%0d cyc=%0d", i, obs_q[i].l, obs_q[i].r, obs_q[i].cyc, exp_q[i].l, exp_q[i].r, exp_q[i].cyc); end
    end
    n_assert++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL hold_frame_err: got %b, want 0", frame_err); end
  endtask

  task automatic test_missing();
    do_reset();
    ch_mask = 6'h3f;
    PSG     = 16'h0000;
    send(3'd0, 9'd20, 9'd20, 2);
    send(3'd1, 9'd20, 9'd20, 2);
    send(3'd2, 9'd20, 9'd20, 2);
    send(3'd4, 9'd20, 9'd20, 2);
    send(3'd5, 9'd20, 9'd20, 2);
    send(3'd0, 9'd20, 9'd20, 2);
    repeat (2) @(negedge MCLK);
    n_assert++;
    if (sample_l !== 16'sd1600) begin n_fail++; $display("FAIL missing_l: got %0d, want 1600", sample_l); end
    n_assert++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL missing_err_set: got %b, want 1", frame_err); end
    for (int s = 1; s < 6; s++) send(3'(s), 9'd20, 9'd20, 2);
    send(3'd0, 9'd0, 9'd0, 2);
    repeat (6) @(negedge MCLK);
    n_assert++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL missing_err_sticky: got %b, want 1", frame_err); end
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL missing_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL missing_sample%0d: got l=%0d r=%0d cyc=%0d, want l=%0d r=%0d cyc=%0d", i, obs_q[i].l, obs_q[i].r, obs_q[i].cyc, exp_q[i].l, exp_q[i].r, exp_q[i].cyc); end
    end
  endtask

  task automatic test_mask_mute();
    do_reset();
    ch_mask = 6'b000001;
    PSG     = 16'h0000;
    mute    = 1'b0;
    for (int s = 0; s < 6; s++) send(3'(s), 9'd100, 9'd100, 2);
    send(3'd0, 9'd100, 9'd100, 2);
    repeat (2) @(negedge MCLK);
    n_assert++;
    if (sample_l !== 16'sd1600) begin n_fail++; $display("FAIL mask_l: got %0d, want 1600", sample_l); end
    mute = 1'b1;
    for (int s = 1; s < 6; s++) send(3'(s), 9'd100, 9'd100, 2);
    send(3'd0, 9'd100, 9'd100, 2);
    repeat (2) @(negedge MCLK);
    n_assert++;
    if (sample_l !== 16'sd0) begin n_fail++; $display("FAIL mute_l: got %0d, want 0", sample_l); end
    repeat (4) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL mute_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mute_sample%0d: got l=%0d r=%0d cyc=%0d, want l=%0d r=%0d cyc=%0d", i, obs_q[i].l, obs_q[i].r, obs_q[i].cyc, exp_q[i].l, exp_q[i].r, exp_q[i].cyc); end
    end
    mute = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ch_mask = 6'h3f;
    for (int f = 0; f < 3; f++) begin
      PSG = 16'($urandom);
      for (int s = 0; s < 6; s++) send(3'(s), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2);
    end
    for (int k = 0; k < 3; k++) begin
      PSG = 16'($urandom);
      send(3'd0, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2);
      send(3'd1, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2);
    end
    send(3'd0, 9'd0, 9'd0, 2);
    repeat (6) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_sample%0d: got l=%0d r=%0d cyc=%0d, want l=%0d r=%0d cyc=%0d", i, obs_q[i].l, obs_q[i].r, obs_q[i].cyc, exp_q[i].l, exp_q[i].r, exp_q[i].cyc); end
    end
    n_assert++;
    if (frame_err !== m_err) begin n_fail++; $display("FAIL b2b_frame_err: got %b, want %b", frame_err, m_err); end
  endtask

  task automatic test_random();
    int r;
    int p;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      ch_mask = ($urandom_range(0, 3) == 0) ? 6'h3f : 6'($urandom);
      for (int s = 0; s < 6; s++) begin
        r = int'($urandom_range(0, 15));
        p = int'($urandom_range(2, 4));
        if (s == 0) begin
          PSG  = 16'($urandom);
          mute = ($urandom_range(0, 4) == 0);
        end
        if (r == 0 && s > 1) continue;
        send(3'(s), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), p);
        if (r == 1) send(3'(s), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), p);
        if (r == 2) send(3'($urandom_range(6, 7)), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), p);
      end
    end
    send(3'd0, 9'd0, 9'd0, 2);
    repeat (6) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_sample%0d: got l=%0d r=%0d cyc=%0d, want l=%0d r=%0d cyc=%0d", i, obs_q[i].l, obs_q[i].r, obs_q[i].cyc, exp_q[i].l, exp_q[i].r, exp_q[i].cyc); end
    end
    n_assert++;
    if (frame_err !== m_err) begin n_fail++; $display("FAIL rand_frame_err: got %b, want %b", frame_err, m_err); end
    mute = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    ch_mask = 6'h3f;
    PSG     = 16'h1234;
    send(3'd1, 9'd50, 9'd50, 2);
    send(3'd2, 9'd50, 9'd50, 2);
    #2 SRES = 1'b0;
    mdl_clear();
    #1;
    n_assert++;
    if (sample_l !== 16'sd0 || sample_r !== 16'sd0) begin n_fail++; $display("FAIL midreset_samples: got l=%0d r=%0d, want 0 0", sample_l, sample_r); end
    n_assert++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_err: got %b, want 0", frame_err); end
    @(negedge MCLK);
    SRES = 1'b1;
    @(negedge MCLK);
    send(3'd0, 9'd30, 9'd30, 2);
    repeat (4) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL first_slot0_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
    for (int s = 1; s < 6; s++) send(3'(s), 9'd30, 9'd30, 2);
    send(3'd0, 9'd30, 9'd30, 2);
    SRES = 1'b0;
    mdl_clear();
    repeat (2) @(negedge MCLK);
    SRES = 1'b1;
    repeat (5) @(negedge MCLK);
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL inflight_count: got %0d samples, want %0d", obs_q.size(), exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want end within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_missing();
    test_mask_mute();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
